// File: rtl/cpu_regfile.sv
// cpu_regfile: parametrised register file, 2 registered read ports, 1 write port, pending scoreboard; REGFILE_BYPASS_EN adds write-to-read forwarding
module cpu_regfile #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 2,
    parameter int ZERO_R0 = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              issue,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] ra_q,
    output logic [DATA_W-1:0] rb_q,
    output logic              ra_pend,
    output logic              rb_pend,
    output logic              hazard
);
    localparam int NREG = 1 << ADDR_W;
    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   pend;
    logic              w_ok, i_ok;
    logic [DATA_W-1:0] nd_a, nd_b;
    logic              np_a, np_b;
    // r0 stays zero and never pending because nothing can ever update it
    assign w_ok = we && !(ZERO_R0 != 0 && waddr == '0);
    assign i_ok = issue && !(ZERO_R0 != 0 && issue_addr == '0);
`ifdef REGFILE_BYPASS_EN
    logic hit_a, hit_b;
    assign hit_a = w_ok && waddr == ra_addr;
    assign hit_b = w_ok && waddr == rb_addr;
    always_comb begin
        nd_a = hit_a ? wdata : regs[ra_addr];
        nd_b = hit_b ? wdata : regs[rb_addr];
        np_a = hit_a ? (i_ok && issue_addr == ra_addr) : pend[ra_addr];
        np_b = hit_b ? (i_ok && issue_addr == rb_addr) : pend[rb_addr];
    end
`else
    always_comb begin
        nd_a = regs[ra_addr];
        nd_b = regs[rb_addr];
        np_a = pend[ra_addr];
        np_b = pend[rb_addr];
    end
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            pend    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            ra_pend <= 1'b0;
            rb_pend <= 1'b0;
        end else begin
            if (w_ok) begin
                regs[waddr] <= wdata;
                pend[waddr] <= 1'b0;
            end
            // a same-address issue lands last so the newer producer keeps it pending
            if (i_ok) pend[issue_addr] <= 1'b1;
            ra_q    <= nd_a;
            rb_q    <= nd_b;
            ra_pend <= np_a;
            rb_pend <= np_b;
        end
    end
    assign hazard = ra_pend | rb_pend;
endmodule

// File: tb/tb_cpu_regfile.sv
// tb_cpu_regfile: directed self-checking bench for cpu_regfile (ZERO_R0=0 and ZERO_R0=1 instances)
module tb_cpu_regfile;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0, issue = 1'b0;
    logic [1:0]  waddr = '0, issue_addr = '0, ra_addr = '0, rb_addr = '0;
    logic [15:0] wdata = '0;
    logic [15:0] ra_q0, rb_q0, ra_q1, rb_q1;
    logic        ra_p0, rb_p0, hz0, ra_p1, rb_p1, hz1;
    int          n_cmp = 0, n_bad = 0;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    cpu_regfile #(.DATA_W(16), .ADDR_W(2), .ZERO_R0(0)) u0 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .issue(issue), .issue_addr(issue_addr), .ra_addr(ra_addr), .rb_addr(rb_addr),
        .ra_q(ra_q0), .rb_q(rb_q0), .ra_pend(ra_p0), .rb_pend(rb_p0), .hazard(hz0));
    cpu_regfile #(.DATA_W(16), .ADDR_W(2), .ZERO_R0(1)) u1 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .issue(issue), .issue_addr(issue_addr), .ra_addr(ra_addr), .rb_addr(rb_addr),
        .ra_q(ra_q1), .rb_q(rb_q1), .ra_pend(ra_p1), .rb_pend(rb_p1), .hazard(hz1));

    always #5 clk = ~clk;

    task automatic cyc;
        @(negedge clk);
    endtask

    task automatic test_reset;
        #1 rst = 1'b0;
        #1;
        n_cmp++; if ({ra_q0, rb_q0, ra_p0, rb_p0, hz0} !== 35'd0) begin n_bad++; $display("FAIL reset_async_u0 got %h want 0", {ra_q0, rb_q0, ra_p0, rb_p0, hz0}); end
        n_cmp++; if ({ra_q1, rb_q1, ra_p1, rb_p1, hz1} !== 35'd0) begin n_bad++; $display("FAIL reset_async_u1 got %h want 0", {ra_q1, rb_q1, ra_p1, rb_p1, hz1}); end
        cyc();
        rst = 1'b1;
        for (int a = 0; a < 4; a++) begin
            ra_addr = 2'(a);
            rb_addr = 2'(3 - a);
            cyc();
            n_cmp++; if ({ra_q0, rb_q0, ra_p0, rb_p0, hz0} !== 35'd0) begin n_bad++; $display("FAIL reset_read r%0d got %h want 0", a, {ra_q0, rb_q0, ra_p0, rb_p0, hz0}); end
        end
    endtask

    task automatic test_write;
        we = 1'b1; waddr = 2'd2; wdata = 16'hA5A5; ra_addr = 2'd0;
        cyc();
        we = 1'b0; ra_addr = 2'd2; rb_addr = 2'd1;
        cyc();
        n_cmp++; if (ra_q0 !== 16'hA5A5) begin n_bad++; $display("FAIL write_ra got %h want a5a5", ra_q0); end
        n_cmp++; if (rb_q0 !== 16'h0000) begin n_bad++; $display("FAIL write_rb got %h want 0000", rb_q0); end
        rb_addr = 2'd2;
        cyc();
        n_cmp++; if (rb_q0 !== ra_q0 || rb_q0 !== 16'hA5A5) begin n_bad++; $display("FAIL same_reg_both got %h/%h want a5a5", ra_q0, rb_q0); end
    endtask

    task automatic test_pending;
        issue = 1'b1; issue_addr = 2'd3; ra_addr = 2'd0; rb_addr = 2'd0;
        cyc();
        issue = 1'b0; rb_addr = 2'd3;
        cyc();
        n_cmp++; if (rb_p0 !== 1'b1) begin n_bad++; $display("FAIL pend_set got %b want 1", rb_p0); end
        n_cmp++; if (hz0 !== 1'b1) begin n_bad++; $display("FAIL hazard_set got %b want 1", hz0); end
        n_cmp++; if (ra_p0 !== 1'b0) begin n_bad++; $display("FAIL pend_other got %b want 0", ra_p0); end
        we = 1'b1; waddr = 2'd3; wdata = 16'h0042;
        cyc();
        n_cmp++; if (rb_p0 !== !BYP || rb_q0 !== (BYP ? 16'h0042 : 16'h0000)) begin n_bad++; $display("FAIL pend_write_same_cycle got %b/%h want %b/%h", rb_p0, rb_q0, !BYP, BYP ? 16'h0042 : 16'h0000); end
        we = 1'b0;
        cyc();
        n_cmp++; if (rb_p0 !== 1'b0 || rb_q0 !== 16'h0042) begin n_bad++; $display("FAIL pend_clear got %b/%h want 0/0042", rb_p0, rb_q0); end
        n_cmp++; if (hz0 !== 1'b0) begin n_bad++; $display("FAIL hazard_clear got %b want 0", hz0); end
    endtask

    task automatic test_bypass;
        we = 1'b1; waddr = 2'd1; wdata = 16'h1234; ra_addr = 2'd1;
        cyc();
        n_cmp++; if (ra_q0 !== (BYP ? 16'h1234 : 16'h0000)) begin n_bad++; $display("FAIL bypass_same_cycle got %h want %h", ra_q0, BYP ? 16'h1234 : 16'h0000); end
        we = 1'b0;
        cyc();
        n_cmp++; if (ra_q0 !== 16'h1234) begin n_bad++; $display("FAIL bypass_next got %h want 1234", ra_q0); end
    endtask

    task automatic test_issue_write;
        issue = 1'b1; issue_addr = 2'd1; we = 1'b1; waddr = 2'd1; wdata = 16'h5555; ra_addr = 2'd1;
        cyc();
        n_cmp++; if (ra_p0 !== BYP || ra_q0 !== (BYP ? 16'h5555 : 16'h1234)) begin n_bad++; $display("FAIL iw_same_cycle got %b/%h want %b/%h", ra_p0, ra_q0, BYP, BYP ? 16'h5555 : 16'h1234); end
        issue = 1'b0; we = 1'b0;
        cyc();
        n_cmp++; if (ra_p0 !== 1'b1 || ra_q0 !== 16'h5555 || hz0 !== 1'b1) begin n_bad++; $display("FAIL iw_same_addr got %b/%h/%b want 1/5555/1", ra_p0, ra_q0, hz0); end
        issue = 1'b1; issue_addr = 2'd2; we = 1'b1; waddr = 2'd3; wdata = 16'h7777;
        cyc();
        issue = 1'b0; we = 1'b0; ra_addr = 2'd2; rb_addr = 2'd3;
        cyc();
        n_cmp++; if (ra_p0 !== 1'b1 || ra_q0 !== 16'hA5A5) begin n_bad++; $display("FAIL iw_diff_issue got %b/%h want 1/a5a5", ra_p0, ra_q0); end
        n_cmp++; if (rb_p0 !== 1'b0 || rb_q0 !== 16'h7777) begin n_bad++; $display("FAIL iw_diff_write got %b/%h want 0/7777", rb_p0, rb_q0); end
    endtask

    task automatic test_zero_r0;
        we = 1'b1; waddr = 2'd0; wdata = 16'hFFFF; issue = 1'b1; issue_addr = 2'd0; ra_addr = 2'd0; rb_addr = 2'd0;
        cyc();
        n_cmp++; if (ra_q1 !== 16'h0000 || ra_p1 !== 1'b0) begin n_bad++; $display("FAIL zero_same_cycle got %h/%b want 0000/0", ra_q1, ra_p1); end
        we = 1'b0; issue = 1'b0;
        cyc();
        n_cmp++; if ({ra_q1, rb_q1, ra_p1, rb_p1, hz1} !== 35'd0) begin n_bad++; $display("FAIL zero_r0 got %h want 0", {ra_q1, rb_q1, ra_p1, rb_p1, hz1}); end
        n_cmp++; if (ra_q0 !== 16'hFFFF || ra_p0 !== 1'b1) begin n_bad++; $display("FAIL plain_r0 got %h/%b want ffff/1", ra_q0, ra_p0); end
    endtask

    task automatic test_async_reset;
        ra_addr = 2'd2; rb_addr = 2'd1;
        cyc();
        n_cmp++; if (ra_p1 !== 1'b1 || ra_q1 !== 16'hA5A5) begin n_bad++; $display("FAIL pre_reset got %b/%h want 1/a5a5", ra_p1, ra_q1); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if ({ra_q1, rb_q1, ra_p1, rb_p1, hz1} !== 35'd0) begin n_bad++; $display("FAIL mid_reset got %h want 0", {ra_q1, rb_q1, ra_p1, rb_p1, hz1}); end
        cyc();
        rst = 1'b1;
        cyc();
        n_cmp++; if ({ra_q0, rb_q0, ra_p0, rb_p0} !== 34'd0) begin n_bad++; $display("FAIL post_reset got %h want 0", {ra_q0, rb_q0, ra_p0, rb_p0}); end
        we = 1'b1; waddr = 2'd2; wdata = 16'h0BEE;
        cyc();
        we = 1'b0;
        cyc();
        n_cmp++; if (ra_q1 !== 16'h0BEE || ra_p1 !== 1'b0) begin n_bad++; $display("FAIL write_after_reset got %h/%b want 0bee/0", ra_q1, ra_p1); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_pending();
        test_bypass();
        test_issue_write();
        test_zero_r0();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cpu_regfile.md
# cpu_regfile

Parametrised general-purpose register file for the lab CPU datapath, replacing the fixed four-entry, 16-bit register group. It holds 2^ADDR_W registers of DATA_W bits and provides two registered read ports plus one write port fed by the ALU result. A per-register pending scoreboard lets the control unit track in-flight writebacks and stall on read-after-write hazards. Write-to-read forwarding can be compiled in.

## Interface
- DATA_W, 16, register width in bits (≥1)
- ADDR_W, 2, address width; NREG = 2^ADDR_W registers
- ZERO_R0, 0, 1 = register 0 reads as zero, ignores writes, is never pending

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- we  in  1  write enable for the writeback port
- waddr  in  ADDR_W  writeback register address
- wdata  in  DATA_W  writeback data (ALU result)
- issue  in  1  mark register issue_addr pending (a result is in flight)
- issue_addr  in  ADDR_W  destination of the issued instruction
- ra_addr  in  ADDR_W  read port A address (rd operand)
- rb_addr  in  ADDR_W  read port B address (rs operand)
- ra_q  out  DATA_W  registered read data, port A
- rb_q  out  DATA_W  registered read data, port B
- ra_pend  out  1  registered pending flag of the register read on port A
- rb_pend  out  1  registered pending flag of the register read on port B
- hazard  out  1  combinational: ra_pend | rb_pend

## Operation
- Storage: NREG × DATA_W registers plus NREG pending bits.
- Reset (rst low, asynchronous): every register is 0, every pending bit is 0, and ra_q, rb_q, ra_pend, rb_pend and hazard are all 0.
- Write: on a clock edge with we=1, reg[waddr] ← wdata and pend[waddr] ← 0.
- Issue: on a clock edge with issue=1, pend[issue_addr] ← 1.
- Issue and write to the same address in the same cycle: the register takes wdata, and pend stays 1 because issue wins (a newer producer is now in flight).
- Issue and write to different addresses in the same cycle: both take effect independently.
- Reads: on every edge, ra_q ← reg[ra_addr], rb_q ← reg[rb_addr], ra_pend ← pend[ra_addr], rb_pend ← pend[rb_addr]. These values are sampled as the array held before the edge, unless forwarding applies (see Configuration).
- Both read ports may address the same register; they return identical data.
- ZERO_R0=1:
  - Writes and issues to address 0 are discarded.
  - A read of address 0 always returns data 0 and pending 0.
- Writes are unconditional when we=1, independent of the pending state. Sequencing is the control unit's responsibility.
- Reset asserted mid-operation clears all state immediately, including in-flight pending bits. Any writeback arriving after release is an ordinary write.

## Timing
- Read latency is 1 cycle: an address presented before edge N appears on ra_q/rb_q after edge N.
- Write latency is 1 cycle: the value is visible to a read addressed on the following cycle.
- Pending set or clear becomes visible on ra_pend/rb_pend one cycle after the read that follows the update.
- hazard has no register stage beyond ra_pend/rb_pend.
- No handshake: all inputs are sampled every edge, so the controller holds addresses stable as required.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read whose address equals waddr while we=1 in the same cycle captures wdata, and its pending output captures 0 (or 1 if issue also targets that address in the same cycle).
  - The zero-register rule overrides forwarding.
- REGFILE_BYPASS_EN undefined:
  - The same-cycle read captures the old register value and the old pending bit.
  - The new value is visible one cycle later.

## Test plan
- Reset then read all addresses → ra_q = rb_q = 0 and ra_pend = rb_pend = hazard = 0 for every register.
- Write 16'hA5A5 to r2, next cycle read ra=r2, rb=r1 → one cycle later ra_q = A5A5, rb_q = 0.
- Issue r3; read r3 on port B → rb_pend = 1, hazard = 1. Then write 16'h0042 to r3 → the next read shows rb_pend = 0 and rb_q = 0042.
- Same cycle: write 16'h1234 to r1 and read r1 on port A → ra_q = 1234 with REGFILE_BYPASS_EN, and the prior value 0 without it.
- Same cycle: issue r1 and write 16'h5555 to r1 → r1 = 5555 and ra_pend = 1 on a later read.
- ZERO_R0=1: write FFFF and issue to r0 → reads of r0 give data 0 and pending 0. Assert rst while r2 is pending → r2 data 0 and pending 0 immediately.
